// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and parameter ranges for the input debouncer
package debounce_pkg;
    typedef enum logic [3:0] {
        LOW       = 4'b0001,
        RISE_WAIT = 4'b0010,
        HIGH      = 4'b0100,
        FALL_WAIT = 4'b1000
    } state_t;
    localparam int SYNC_MIN   = 2;
    localparam int SYNC_MAX   = 4;
    localparam int STABLE_MIN = 2;
    localparam int STABLE_MAX = 65535;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: metastability flop chain bringing an asynchronous level into the clk domain
module sync_chain
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_stages
        $error("sync_chain: SYNC_STAGES out of range");
    end
    logic [SYNC_STAGES-1:0] ff;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '0;
        else     ff <= {ff[SYNC_STAGES-2:0], d};
    end
    assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronises a bouncy level, accepts a change only after a stable run,
// and emits a registered clean level with single-cycle rise/fall pulses
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    input  logic en,
    output logic a_out,
    output logic rise,
    output logic fall,
    output logic busy
);
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("input_debouncer: SYNC_STAGES out of range");
    end
    if (STABLE_CYCLES < STABLE_MIN || STABLE_CYCLES > STABLE_MAX) begin : g_bad_stable
        $error("input_debouncer: STABLE_CYCLES out of range");
    end
    if (CNT_W < $clog2(STABLE_CYCLES)) begin : g_bad_cnt
        $error("input_debouncer: CNT_W too narrow");
    end
    logic s;
    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (s)
    );
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             lo_side, waiting, want, done;
    // want: the synced level differs from the accepted one and qualification is enabled
    always_comb begin
        lo_side = state == LOW || state == RISE_WAIT;
        waiting = state == RISE_WAIT || state == FALL_WAIT;
        want    = en && (s == lo_side);
        done    = waiting && want && cnt == CNT_W'(STABLE_CYCLES - 1);
        cnt_n   = waiting ? ((want && !done) ? cnt + 1'b1 : '0) : (want ? CNT_W'(1) : '0);
        state_n = LOW;
        case (state)
            LOW:       state_n = want ? RISE_WAIT : LOW;
            RISE_WAIT: state_n = !want ? LOW : (done ? HIGH : RISE_WAIT);
            HIGH:      state_n = want ? FALL_WAIT : HIGH;
            FALL_WAIT: state_n = !want ? HIGH : (done ? LOW : FALL_WAIT);
            default:   state_n = LOW;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOW;
            cnt   <= '0;
            a_out <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rise  <= done && state == RISE_WAIT;
            fall  <= done && state == FALL_WAIT;
            if (done) a_out <= state == RISE_WAIT;
        end
    end
    assign busy = waiting;
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed edge checks plus a per-cycle scoreboard on two configurations
module tb_input_debouncer;
    logic clk = 1'b0, rst = 1'b1;
    logic raw0 = 1'b0, en0 = 1'b1, raw1 = 1'b0, en1 = 1'b1;
    logic a0, r0, f0, b0, a1, r1, f1, b1;
    int   total = 0, bad = 0;
    bit   sb_on = 1'b1, t6 = 1'b0;
    int   trans1 = 0, pulses1 = 0;
    logic a1_prev = 1'b0;
    logic [3:0] e0, e1;
    logic [3:0] q0[$], q1[$];

    typedef struct packed {
        logic [3:0]  sync;
        logic [15:0] run;
        logic        a, r, f, b;
    } mdl_t;
    mdl_t m0, m1;

    always #5 clk = ~clk;

    input_debouncer dut (
        .clk(clk), .rst(rst), .raw_in(raw0), .en(en0),
        .a_out(a0), .rise(r0), .fall(f0), .busy(b0)
    );
    input_debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(2)) dut_fast (
        .clk(clk), .rst(rst), .raw_in(raw1), .en(en1),
        .a_out(a1), .rise(r1), .fall(f1), .busy(b1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // run-length model: flip once `sc` consecutive enabled synced samples disagree with the level
    function automatic mdl_t step(input mdl_t m, input int ss, input int sc, input logic raw, input logic en);
        mdl_t n = m;
        logic s = m.sync[ss-1];
        n.sync = {m.sync[2:0], raw};
        n.r = 1'b0;
        n.f = 1'b0;
        if (en && s != m.a) begin
            n.run = m.run + 16'd1;
            if (int'(n.run) == sc) begin
                n.a = s;
                n.r = s;
                n.f = !s;
                n.run = '0;
            end
        end else n.run = '0;
        n.b = n.run != 0;
        return n;
    endfunction

    always @(posedge clk) begin : model
        mdl_t n0, n1;
        n0 = rst ? mdl_t'(0) : step(m0, 2, 8, raw0, en0);
        n1 = rst ? mdl_t'(0) : step(m1, 3, 2, raw1, en1);
        m0 <= n0;
        m1 <= n1;
        q0.push_back({n0.a, n0.r, n0.f, n0.b});
        q1.push_back({n1.a, n1.r, n1.f, n1.b});
    end

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            if (sb_on) chk("sb_dflt", 32'({a0, r0, f0, b0}), 32'(e0));
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            if (sb_on) chk("sb_fast", 32'({a1, r1, f1, b1}), 32'(e1));
        end
        if (t6) begin
            if (r1 || f1) pulses1++;
            if (a1 != a1_prev) trans1++;
        end
        a1_prev = a1;
    end

    initial begin
        int ed, nr, nf;
        repeat (3) tick();
        chk("rst_a", 32'(a0), 0);
        chk("rst_busy", 32'(b0), 0);
        chk("rst_rise", 32'(r0), 0);
        chk("rst_fall", 32'(f0), 0);
        rst = 1'b0;
        raw0 = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 2) chk("t1_busy_e2", 32'(b0), 0);
            if (e == 3) chk("t1_busy_e3", 32'(b0), 1);
            if (e == 9) chk("t1_a_e9", 32'(a0), 0);
            if (e == 10) begin
                chk("t1_a_e10", 32'(a0), 1);
                chk("t1_rise_e10", 32'(r0), 1);
            end
            if (e == 11) chk("t1_rise_e11", 32'(r0), 0);
        end
        raw0 = 1'b0;
        nr = 0;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (r0) nr++;
            if (e == 9) chk("t3_a_e9", 32'(a0), 1);
            if (e == 10) begin
                chk("t3_fall_e10", 32'(f0), 1);
                chk("t3_a_e10", 32'(a0), 0);
            end
            if (e == 11) chk("t3_fall_e11", 32'(f0), 0);
        end
        chk("t3_no_rise", 32'(nr), 0);
        raw0 = 1'b1;
        nr = 0;
        repeat (5) begin
            tick();
            if (r0) nr++;
        end
        raw0 = 1'b0;
        tick();
        if (r0) nr++;
        raw0 = 1'b1;
        chk("t2_bounce_quiet", 32'(nr), 0);
        nr = 0;
        ed = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (r0) begin
                nr++;
                if (ed == 0) ed = e;
            end
        end
        chk("t2_rise_edge", 32'(ed), 10);
        chk("t2_rise_count", 32'(nr), 1);
        raw0 = 1'b0;
        repeat (12) tick();
        chk("t4_pre_low", 32'(a0), 0);
        raw0 = 1'b1;
        repeat (6) tick();
        chk("t4_busy_on", 32'(b0), 1);
        en0 = 1'b0;
        tick();
        chk("t4_abort_busy", 32'(b0), 0);
        chk("t4_abort_a", 32'(a0), 0);
        nr = 0;
        repeat (3) begin
            tick();
            if (r0) nr++;
        end
        chk("t4_no_pulse", 32'(nr), 0);
        chk("t4_idle_busy", 32'(b0), 0);
        en0 = 1'b1;
        ed = 0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (r0 && ed == 0) ed = e;
        end
        chk("t4_rise_edge", 32'(ed), 8);
        raw0 = 1'b0;
        repeat (5) tick();
        chk("t5_fall_wait", 32'(b0), 1);
        #2;
        sb_on = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_async_a", 32'(a0), 0);
        chk("t5_async_busy", 32'(b0), 0);
        tick();
        sb_on = 1'b1;
        tick();
        rst = 1'b0;
        nf = 0;
        repeat (20) begin
            tick();
            if (f0) nf++;
        end
        chk("t5_no_fall", 32'(nf), 0);
        chk("t5_a_low", 32'(a0), 0);
        t6 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            raw1 = ~raw1;
            repeat ($urandom_range(1, 5)) tick();
        end
        repeat (8) tick();
        t6 = 1'b0;
        chk("t6_pulse_vs_trans", 32'(pulses1), 32'(trans1));
        chk("t6_active", 32'(trans1 > 0), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
